// File: rtl/sram_1rwm_param_if.sv
// Request/response bundle for sram_1rwm_param.
// The requester (master) drives the request fields and rsp_ready;
// the RAM (slave) drives req_ready and the response fields.
interface sram_1rwm_param_if #(
    parameter int DEPTH     = 256,
    parameter int LANES     = 32,
    parameter int LANE_BITS = 9
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int W         = LANES * LANE_BITS;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr;
    logic [W-1:0]         req_wdata;
    logic [LANES-1:0]     req_wmask;
    logic                 req_perr_inject;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W-1:0]         rsp_rdata;
    logic [LANES-1:0]     rsp_perr;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, req_perr_inject, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_perr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, req_perr_inject, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_perr
    );
endinterface

// File: rtl/sram_1rwm_param.sv
// Parametrised single-port lane-masked SRAM with valid/ready request and
// response channels, a one-entry response register and a zero-init sequencer
// that clears every word after reset before any request is taken.
// Optional feature: define SRAM_PARITY_EN to store one even-parity bit per
// lane and report per-lane parity errors on rsp_perr; otherwise rsp_perr is 0.
module sram_1rwm_param #(
    parameter int DEPTH     = 256,
    parameter int LANES     = 32,
    parameter int LANE_BITS = 9
) (
    input  logic                clock,
    input  logic                reset_n,
    sram_1rwm_param_if.slave    bus,
    output logic                init_busy,
    input  logic                volt_sel
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int W         = LANES * LANE_BITS;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] init_cnt;

    logic [W-1:0]         mem_data [DEPTH];

    logic                 accept;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [W-1:0]         mem_wdata;
    logic [LANES-1:0]     mem_lane_we;

    logic [W-1:0]         rd_word;
    logic [LANES-1:0]     rd_perr;

    // volt_sel only steers the hard macro; the behavioural model ignores it
    logic                 unused_ok;
    assign unused_ok = ^{volt_sel, bus.req_perr_inject};

    assign bus.req_ready = (state == ST_RUN) && (!bus.rsp_valid || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // Sequencer: walk every address once after reset, then hand over to requests
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + ADDR_BITS'(1);
            if (init_cnt == ADDR_BITS'(DEPTH - 1)) begin
                state     <= ST_RUN;
                init_busy <= 1'b0;
            end
        end
    end

    // Single write port shared between the zero-init sweep and masked writes
    always_comb begin
        mem_addr    = bus.req_addr;
        mem_wdata   = bus.req_wdata;
        mem_lane_we = '0;
        if (state == ST_INIT) begin
            mem_addr    = init_cnt;
            mem_wdata   = '0;
            mem_lane_we = '1;
        end else if (accept && bus.req_write) begin
            mem_lane_we = bus.req_wmask;
        end
    end

    // Data array update, one enable per lane so unmasked lanes keep their contents
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_lane_we[i]) begin
                mem_data[mem_addr][i*LANE_BITS +: LANE_BITS] <= mem_wdata[i*LANE_BITS +: LANE_BITS];
            end
        end
    end

    assign rd_word = mem_data[bus.req_addr];

`ifdef SRAM_PARITY_EN
    logic [LANES-1:0] mem_par [DEPTH];
    logic [LANES-1:0] mem_wpar;

    // Even parity per lane; the inject hook flips it only for requested writes
    always_comb begin
        mem_wpar = '0;
        for (int i = 0; i < LANES; i++) begin
            mem_wpar[i] = (^mem_wdata[i*LANE_BITS +: LANE_BITS]) ^
                          ((state == ST_RUN) && bus.req_perr_inject);
        end
    end

    // Parity array update, written alongside the data lanes
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_lane_we[i]) begin
                mem_par[mem_addr][i] <= mem_wpar[i];
            end
        end
    end

    // A lane is in error when its stored parity disagrees with its stored data
    always_comb begin
        rd_perr = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_perr[i] = (^rd_word[i*LANE_BITS +: LANE_BITS]) ^ mem_par[bus.req_addr][i];
        end
    end
`else
    assign rd_perr = '0;
`endif

    // One-entry response register: load on read accept, hold under backpressure
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_perr  <= '0;
        end else if (accept && !bus.req_write) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= rd_word;
            bus.rsp_perr  <= rd_perr;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sram_1rwm_param.sv
// Directed self-checking bench for sram_1rwm_param (DEPTH=256, 32 lanes of 9 bits).
// Expected parity results follow SRAM_PARITY_EN as seen by this compile.
module tb_sram_1rwm_param;
    localparam int DEPTH     = 256;
    localparam int LANES     = 32;
    localparam int LANE_BITS = 9;
    localparam int W         = LANES * LANE_BITS;
`ifdef SRAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clock;
    logic reset_n;
    logic init_busy;
    logic volt_sel;

    int checks;
    int fails;

    sram_1rwm_param_if #(.DEPTH(DEPTH), .LANES(LANES), .LANE_BITS(LANE_BITS)) bus ();

    sram_1rwm_param #(.DEPTH(DEPTH), .LANES(LANES), .LANE_BITS(LANE_BITS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .init_busy (init_busy),
        .volt_sel  (volt_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         write;
        logic [7:0]   addr;
        logic [W-1:0] wdata;
        logic [31:0]  wmask;
        logic         inject;
        logic [W-1:0] exp_rdata;
        logic [31:0]  exp_perr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [W-1:0] pattern(input int seed);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < LANES; i++) begin
            p[i*LANE_BITS +: LANE_BITS] = LANE_BITS'((seed * 37 + i * 11 + 1) % 512);
        end
        return p;
    endfunction

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                           input logic [31:0] mask);
        logic [W-1:0] r;
        r = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) r[i*LANE_BITS +: LANE_BITS] = new_w[i*LANE_BITS +: LANE_BITS];
        end
        return r;
    endfunction

    function automatic vec_t mkWr(input int addr, input logic [W-1:0] d, input logic [31:0] m,
                                  input logic inj);
        vec_t v;
        v.write = 1'b1; v.addr = 8'(addr); v.wdata = d; v.wmask = m; v.inject = inj;
        v.exp_rdata = '0; v.exp_perr = '0;
        return v;
    endfunction

    function automatic vec_t mkRd(input int addr, input logic [W-1:0] e, input logic [31:0] ep);
        vec_t v;
        v.write = 1'b0; v.addr = 8'(addr); v.wdata = '0; v.wmask = '0; v.inject = 1'b0;
        v.exp_rdata = e; v.exp_perr = ep;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clock);
        bus.req_valid       = 1'b1;
        bus.req_write       = v.write;
        bus.req_addr        = v.addr;
        bus.req_wdata       = v.wdata;
        bus.req_wmask       = v.wmask;
        bus.req_perr_inject = v.inject;
        #1;
        checkOutput($sformatf("vec%0d_req_ready", idx), W'(bus.req_ready), W'(1));
        @(negedge clock);
        bus.req_valid       = 1'b0;
        bus.req_perr_inject = 1'b0;
        if (v.write) begin
            checkOutput($sformatf("vec%0d_no_rsp", idx), W'(bus.rsp_valid), W'(0));
        end else begin
            checkOutput($sformatf("vec%0d_rsp_valid", idx), W'(bus.rsp_valid), W'(1));
            checkOutput($sformatf("vec%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
            checkOutput($sformatf("vec%0d_perr", idx), W'(bus.rsp_perr), W'(v.exp_perr));
        end
    endtask

    // Counts negedge samples with init_busy high, starting at the release instant
    task automatic waitInit(output int busy_cycles, output int bad);
        busy_cycles = 0;
        bad = 0;
        for (int c = 0; c < 1000 && init_busy === 1'b1; c++) begin
            busy_cycles++;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) bad++;
            @(negedge clock);
        end
    endtask

    task automatic checkInitDone(input string tag);
        int busy_cycles;
        int bad;
        waitInit(busy_cycles, bad);
        checkOutput({tag, "_busy_cycles"}, W'(busy_cycles), W'(DEPTH));
        checkOutput({tag, "_quiet_during_init"}, W'(bad), W'(0));
        checkOutput({tag, "_init_busy_low"}, W'(init_busy), W'(0));
        checkOutput({tag, "_req_ready_high"}, W'(bus.req_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] exp5;
        logic [W-1:0] exp7;
        logic [W-1:0] exp9;
        logic [W-1:0] tp_exp [3];

        checks = 0;
        fails  = 0;
        ones   = '1;
        reset_n             = 1'b0;
        volt_sel            = 1'b0;
        bus.req_valid       = 1'b0;
        bus.req_write       = 1'b0;
        bus.req_addr        = '0;
        bus.req_wdata       = '0;
        bus.req_wmask       = '0;
        bus.req_perr_inject = 1'b0;
        bus.rsp_ready       = 1'b1;

        exp5     = W'(9'h1FF);
        exp7     = merge('0, pattern(7), 32'h0000_0006);
        exp9     = merge('0, pattern(9), 32'h0000_0006);
        tp_exp[0] = pattern(1);
        tp_exp[1] = pattern(2);
        tp_exp[2] = pattern(3);

        vecs.push_back(mkRd(0,   '0, '0));
        vecs.push_back(mkRd(128, '0, '0));
        vecs.push_back(mkRd(255, '0, '0));
        vecs.push_back(mkWr(5, ones, 32'h0000_0001, 1'b0));
        vecs.push_back(mkRd(5, exp5, '0));
        vecs.push_back(mkWr(5, '0, 32'h8000_0000, 1'b0));
        vecs.push_back(mkRd(5, exp5, '0));
        vecs.push_back(mkWr(5, ones, 32'h0000_0000, 1'b0));
        vecs.push_back(mkRd(5, exp5, '0));
        vecs.push_back(mkWr(1, pattern(1), 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mkWr(2, pattern(2), 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mkWr(3, pattern(3), 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mkWr(7, pattern(7), 32'h0000_0006, 1'b1));
        vecs.push_back(mkRd(7, exp7, PAR_EN ? 32'h0000_0006 : 32'h0));
        vecs.push_back(mkWr(9, pattern(9), 32'h0000_0006, 1'b0));
        vecs.push_back(mkRd(9, exp9, '0));
        vecs.push_back(mkRd(1, pattern(1), '0));

        // Reset values
        @(negedge clock);
        checkOutput("rst_req_ready", W'(bus.req_ready), W'(0));
        checkOutput("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, '0);
        checkOutput("rst_rsp_perr", W'(bus.rsp_perr), W'(0));
        checkOutput("rst_init_busy", W'(init_busy), W'(1));

        @(negedge clock);
        reset_n = 1'b1;
        checkInitDone("init1");

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Backpressure: read 5 held for 4 cycles, read 7 waiting behind it
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd5;
        @(negedge clock);
        bus.req_addr  = 8'd7;
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("bp%0d_valid", c), W'(bus.rsp_valid), W'(1));
            checkOutput($sformatf("bp%0d_rdata", c), bus.rsp_rdata, exp5);
            checkOutput($sformatf("bp%0d_req_ready", c), W'(bus.req_ready), W'(0));
            if (c < 3) @(negedge clock);
        end
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", W'(bus.req_ready), W'(1));
        @(negedge clock);
        bus.req_valid = 1'b0;
        checkOutput("bp_next_valid", W'(bus.rsp_valid), W'(1));
        checkOutput("bp_next_rdata", bus.rsp_rdata, exp7);
        checkOutput("bp_next_perr", W'(bus.rsp_perr), W'(PAR_EN ? 32'h0000_0006 : 32'h0));
        @(negedge clock);
        checkOutput("bp_pop_drop", W'(bus.rsp_valid), W'(0));

        // Throughput: reads of 1, 2, 3 on consecutive cycles
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (k < 2) bus.req_addr = 8'(k + 2);
            else bus.req_valid = 1'b0;
            checkOutput($sformatf("tp%0d_valid", k), W'(bus.rsp_valid), W'(1));
            checkOutput($sformatf("tp%0d_rdata", k), bus.rsp_rdata, tp_exp[k]);
        end
        @(negedge clock);
        checkOutput("tp_end_valid", W'(bus.rsp_valid), W'(0));

        // Reset with a held response pending drops it
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'd3;
        @(negedge clock);
        bus.req_valid = 1'b0;
        checkOutput("pend_valid", W'(bus.rsp_valid), W'(1));
        reset_n = 1'b0;
        #1;
        checkOutput("pend_dropped", W'(bus.rsp_valid), W'(0));
        checkOutput("pend_rdata_clr", bus.rsp_rdata, '0);
        checkOutput("pend_init_busy", W'(init_busy), W'(1));
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;

        // Reset again at init cycle 100; the sweep must restart from scratch
        repeat (100) @(negedge clock);
        checkOutput("mid_init_busy_before", W'(init_busy), W'(1));
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checkInitDone("init2");

        // Contents written earlier are cleared by the new sweep
        applyStimulus(mkRd(5, '0, '0), 100);
        applyStimulus(mkRd(3, '0, '0), 101);
        applyStimulus(mkRd(7, '0, '0), 102);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sram_1rwm_param.md
# sram_1rwm_param

Parametrised single-port, lane-masked SRAM with a valid/ready request/response interface, a hardware zero-initialisation sequencer and an optional per-lane parity check. It replaces the fixed 256x288 masked RAM in cache and scratchpad data arrays. Lane widths, lane counts and depth are set per instance, and a one-entry response register absorbs consumer backpressure.

## Interface
- DEPTH, 256, number of words; power of two, >= 2
- LANES, 32, number of independently write-maskable lanes per word
- LANE_BITS, 9, bits per lane; word width W = LANES*LANE_BITS
- ADDR_BITS, $clog2(DEPTH), address width (derived; do not override)
- clock  in  1  rising-edge clock, single domain
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = masked write, 0 = read
- req_addr  in  ADDR_BITS  word address
- req_wdata  in  W  write data, lane i = bits [i*LANE_BITS +: LANE_BITS]
- req_wmask  in  LANES  per-lane write enable (ignored for reads)
- req_perr_inject  in  1  on a write, store inverted parity for written lanes (test hook)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  W  read data
- rsp_perr  out  LANES  per-lane parity error for rsp_rdata
- init_busy  out  1  zero-initialisation in progress
- volt_sel  in  1  voltage-mode select, passed to the macro; no functional effect in behavioural model

## Operation
- States: INIT, RUN. Reset enters INIT with the init counter at 0.
- INIT: write all-zero data, with good parity if enabled, to address cnt. Increment cnt once per cycle. After writing DEPTH-1, go to RUN. Takes exactly DEPTH cycles. init_busy=1 and req_ready=0 throughout.
- RUN: req_ready = ~rsp_valid | rsp_ready.
- Accepted write: lanes with wmask[i]=1 are updated at the clock edge; other lanes keep their contents. No response is produced. A write with wmask=0 is accepted and is a no-op.
- Accepted read: rsp_valid=1 on the next edge, with rsp_rdata/rsp_perr equal to the word contents at acceptance. This includes any write accepted in an earlier cycle.
- Response hold: while rsp_valid & ~rsp_ready, rsp_rdata and rsp_perr stay stable and no new request is accepted.
- Response pop and new read in the same cycle: the new response replaces the old one at the next edge, so full throughput is one read per cycle.
- Response pop with no new read: rsp_valid falls at the next edge.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- Reset mid-operation, including during INIT: everything aborts. The sequencer restarts from 0 and the pending response is dropped.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_perr=0, init_busy=1.
- First possible accept: cycle DEPTH after reset_n deassertion. The first clock edge with reset_n high is cycle 0.
- Read latency: 1 cycle from accept to rsp_valid, with no backpressure.
- Write-to-read: a read accepted in the cycle after a write to the same address returns the new data.
- req_ready depends combinationally on rsp_ready only. There is no path from req_valid to req_ready.

## Configuration
- Macro: SRAM_PARITY_EN.
- Defined: each lane stores one extra even-parity bit, so storage is LANES*(LANE_BITS+1) bits per word. req_perr_inject inverts the stored parity bit of each written lane. On a read, rsp_perr[i]=1 when the stored parity does not match the stored lane data.
- Undefined: no parity storage, req_perr_inject is ignored and rsp_perr is tied to 0.
- The port list is identical in both builds.

## Test plan
- Reset release, DEPTH=256:
  - init_busy=1 and req_ready=0 for 256 cycles, then both flip.
  - Reads of addr 0, 128 and 255 return all-zero data with rsp_perr=0.
- Masked write:
  - Write addr 5, wdata all-ones, wmask=0x0000_0001.
  - Read addr 5 returns lane 0 = 0x1FF and all other lanes 0.
  - Then write wmask=0x8000_0000 with wdata all-zero: the read is unchanged.
- Backpressure:
  - Read addr 5 with rsp_ready held 0 for 4 cycles: rsp_rdata stays stable and req_ready=0 for all 4 cycles.
  - When rsp_ready rises, the next read is accepted in the same cycle.
- Throughput: back-to-back reads of addr 1, 2, 3 with rsp_ready=1 produce three consecutive rsp_valid cycles carrying the contents of 1, 2, 3.
- Reset mid-init: assert reset_n=0 at init cycle 100, then release. init_busy stays 1 for a full 256 cycles and no response appears.
- Parity, SRAM_PARITY_EN defined:
  - Write addr 7, wmask=0x0000_0006, with req_perr_inject=1.
  - Read addr 7 returns rsp_perr=0x0000_0006.
  - Without the macro, the same sequence returns rsp_perr=0.
